b_perceptron_predict: RTL and testbench

//  Consumes the checkNum bundle: up to 4 consecutive conditional branches (B), each with an 8-bit weight-table address.

---
 rtl/b_perceptron_predict_pkg.sv | 39 +++
 rtl/b_perceptron_weight_ram.sv | 37 +++
 rtl/b_perceptron_predict.sv | 153 +++++++++++++++
 tb/tb_b_perceptron_predict.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/b_perceptron_predict_pkg.sv
// ---------------------------------------------------------------------------
// b_perceptron_predict_pkg
// Shared constants and types for the perceptron conditional-branch predictor.
//   BR_TYPE_B : branch type code of a conditional branch (the only kind this
//               predictor evaluates)
//   HIST      : global history length, one weight per history bit
//   WW        : signed weight width
//   DEPTH     : weight table rows; equals the modulus checkNum applies to
//               addresses, so any address >= DEPTH is out of range
//   SW        : adder width, wide enough that HIST+1 weights cannot overflow
//   ROW_W     : width of one weight row (bias + HIST weights)
//   state_t   : predictor FSM encoding
//   clampNum  : limits a bundle's branch count to the 4 slots we have
// ---------------------------------------------------------------------------
package b_perceptron_predict_pkg;

  localparam logic [2:0] BR_TYPE_B = 3'd1;

  localparam int HIST  = 8;
  localparam int WW    = 8;
  localparam int DEPTH = 228;
  localparam int SW    = 12;
  localparam int ROW_W = (HIST + 1) * WW;

  // DEPTH at address width so range checks compare like-sized operands
  localparam logic [7:0] DEPTH_A = 8'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_SUM,
    ST_DONE
  } state_t;

  function automatic logic [2:0] clampNum(input logic [3:0] num);
    return (num > 4'd4) ? 3'd4 : num[2:0];
  endfunction

endpackage

// File: rtl/b_perceptron_weight_ram.sv
// ---------------------------------------------------------------------------
// b_perceptron_weight_ram
// DEPTH x ROW_W flop array holding one perceptron weight row per entry.
// Asynchronous read, one synchronous write port, async reset to all-zero.
//   i_clk, i_rstn   : clock, async active-low reset
//   i_wEn           : row write enable
//   i_wAddr_8       : row write address (ignored when >= DEPTH)
//   i_wData         : row write data
//   i_rAddr_8       : row read address
//   o_rData         : row read data (all-zero when address >= DEPTH)
// ---------------------------------------------------------------------------
module b_perceptron_weight_ram
  import b_perceptron_predict_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wEn,
  input  logic [7:0]       i_wAddr_8,
  input  logic [ROW_W-1:0] i_wData,
  input  logic [7:0]       i_rAddr_8,
  output logic [ROW_W-1:0] o_rData
);

  logic [ROW_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wEn && (i_wAddr_8 < DEPTH_A)) begin
      r_mem[i_wAddr_8] <= i_wData;
    end
  end

  // An all-zero row sums to 0, so an out-of-range address predicts taken
  assign o_rData = (i_rAddr_8 < DEPTH_A) ? r_mem[i_rAddr_8] : '0;

endmodule

// File: rtl/b_perceptron_predict.sv
// ---------------------------------------------------------------------------
// b_perceptron_predict
// Predicts up to 4 consecutive conditional branches one at a time with a
// perceptron (bias + one weight per GHR bit), stopping at the first taken
// prediction and speculatively shifting each outcome into the GHR.
//   i_clk, i_rstn      : clock, async active-low reset
//   i_valid / o_ready  : bundle handshake (bNum + 4 x 8-bit row addresses)
//   i_bNum_4           : branch count, values above 4 are clamped
//   i_weightsAddr_32   : row address of branch k at [k*8+:8]
//   o_valid / i_ready  : result handshake
//   o_predTaken_4      : bit k = branch k predicted taken
//   o_predNum_3        : number of branches evaluated
//   o_ghr              : speculative global history
//   i_flush/i_flushGhr : misprediction recovery, restores the GHR
//   i_wEn/i_wAddr_8/i_wData : trainer row write port
// ---------------------------------------------------------------------------
module b_perceptron_predict
  import b_perceptron_predict_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_bNum_4,
  input  logic [31:0]      i_weightsAddr_32,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [3:0]       o_predTaken_4,
  output logic [2:0]       o_predNum_3,
  output logic [HIST-1:0]  o_ghr,
  input  logic             i_flush,
  input  logic [HIST-1:0]  i_flushGhr,
  input  logic             i_wEn,
  input  logic [7:0]       i_wAddr_8,
  input  logic [ROW_W-1:0] i_wData
);

  state_t            r_state;
  logic [2:0]        r_num;
  logic [31:0]       r_addrs;
  logic [2:0]        r_k;
  logic [ROW_W-1:0]  r_row;
  logic [HIST-1:0]   r_ghr;
  logic              r_valid;
  logic [3:0]        r_predTaken;
  logic [2:0]        r_predNum;

  logic [7:0]        w_rdAddr;
  logic [ROW_W-1:0]  w_rdRow;
  logic [2:0]        w_num;
  logic [2:0]        w_kNext;
  logic signed [SW-1:0] w_sum;
  logic              w_taken;

  assign w_rdAddr = r_addrs[{r_k[1:0], 3'b000} +: 8];
  assign w_num    = clampNum(i_bNum_4);
  assign w_kNext  = r_k + 3'd1;

  b_perceptron_weight_ram u_ram (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_wEn     (i_wEn),
    .i_wAddr_8 (i_wAddr_8),
    .i_wData   (i_wData),
    .i_rAddr_8 (w_rdAddr),
    .o_rData   (w_rdRow)
  );

  // Perceptron dot product against a +/-1 history vector: a set GHR bit adds
  // its weight, a clear bit subtracts it. SW is sized so this never wraps.
  always_comb begin
    logic signed [SW-1:0] ext;
    w_sum = SW'(signed'(r_row[WW-1:0]));
    for (int j = 0; j < HIST; j++) begin
      ext = SW'(signed'(r_row[(j+1)*WW +: WW]));
      if (r_ghr[j]) w_sum = w_sum + ext;
      else          w_sum = w_sum - ext;
    end
  end

  assign w_taken = ~w_sum[SW-1];

  // Flush must block acceptance in its own cycle, so ready is gated by it
  assign o_ready = (r_state == ST_IDLE) && !i_flush;

  // Predictor FSM; flush overrides every state and restores the GHR
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_num       <= '0;
      r_addrs     <= '0;
      r_k         <= '0;
      r_row       <= '0;
      r_ghr       <= '0;
      r_valid     <= 1'b0;
      r_predTaken <= '0;
      r_predNum   <= '0;
    end else if (i_flush) begin
      r_state     <= ST_IDLE;
      r_ghr       <= i_flushGhr;
      r_valid     <= 1'b0;
      r_predTaken <= '0;
      r_predNum   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_num       <= w_num;
            r_addrs     <= i_weightsAddr_32;
            r_k         <= '0;
            r_predTaken <= '0;
            r_predNum   <= '0;
            if (w_num == 3'd0) begin
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          r_row   <= w_rdRow;
          r_state <= ST_SUM;
        end
        ST_SUM: begin
          r_predTaken[r_k[1:0]] <= w_taken;
          r_ghr                 <= {r_ghr[HIST-2:0], w_taken};
          r_k                   <= w_kNext;
          if (w_taken || (w_kNext == r_num)) begin
            r_predNum <= w_kNext;
            r_valid   <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_state <= ST_RD;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_valid       = r_valid;
  assign o_predTaken_4 = r_predTaken;
  assign o_predNum_3   = r_predNum;
  assign o_ghr         = r_ghr;

endmodule

// File: tb/tb_b_perceptron_predict.sv
// ---------------------------------------------------------------------------
// tb_b_perceptron_predict
// Directed bench for the perceptron predictor: fixed weight rows, bundles
// with hand-computed outcomes, handshake hold, flush, write/read collision
// and mid-bundle reset.
// ---------------------------------------------------------------------------
module tb_b_perceptron_predict;
  import b_perceptron_predict_pkg::*;

  logic             i_clk;
  logic             i_rstn;
  logic             i_valid;
  logic             o_ready;
  logic [3:0]       i_bNum_4;
  logic [31:0]      i_weightsAddr_32;
  logic             o_valid;
  logic             i_ready;
  logic [3:0]       o_predTaken_4;
  logic [2:0]       o_predNum_3;
  logic [HIST-1:0]  o_ghr;
  logic             i_flush;
  logic [HIST-1:0]  i_flushGhr;
  logic             i_wEn;
  logic [7:0]       i_wAddr_8;
  logic [ROW_W-1:0] i_wData;

  int nAsserts;
  int nFails;
  int cycles;
  logic sawValid;

  localparam logic [ROW_W-1:0] ROW_ZERO  = '0;
  localparam logic [ROW_W-1:0] ROW_BIASM1 = 72'h0000_0000_0000_0000_FF;
  localparam logic [ROW_W-1:0] ROW_20     = 72'h0000_0000_0000_0000_0AFB;

  b_perceptron_predict dut (
    .i_clk            (i_clk),
    .i_rstn           (i_rstn),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_bNum_4         (i_bNum_4),
    .i_weightsAddr_32 (i_weightsAddr_32),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_predTaken_4    (o_predTaken_4),
    .o_predNum_3      (o_predNum_3),
    .o_ghr            (o_ghr),
    .i_flush          (i_flush),
    .i_flushGhr       (i_flushGhr),
    .i_wEn            (i_wEn),
    .i_wAddr_8        (i_wAddr_8),
    .i_wData          (i_wData)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic writeRow(input logic [7:0] addr, input logic [ROW_W-1:0] data);
    @(negedge i_clk);
    i_wEn = 1'b1; i_wAddr_8 = addr; i_wData = data;
    @(negedge i_clk);
    i_wEn = 1'b0;
  endtask

  // Presents a bundle for one edge, optionally writes a row in the cycle
  // after acceptance, then counts edges (accept edge = 1) until o_valid.
  task automatic applyStimulus(input logic [3:0] num, input logic [31:0] addrs,
                               input logic wEn, input logic [7:0] wAddr,
                               input logic [ROW_W-1:0] wData, output int cyc);
    @(negedge i_clk);
    i_valid = 1'b1; i_bNum_4 = num; i_weightsAddr_32 = addrs;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_wEn = wEn; i_wAddr_8 = wAddr; i_wData = wData;
    cyc = 1;
    while (!o_valid && cyc < 40) begin
      @(negedge i_clk);
      i_wEn = 1'b0;
      cyc++;
    end
    i_wEn = 1'b0;
  endtask

  task automatic consume(input string tag);
    @(negedge i_clk);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    checkOutput({tag, "_validDrop"}, 32'(o_valid), 32'd0);
    checkOutput({tag, "_readyBack"}, 32'(o_ready), 32'd1);
  endtask

  // Flush while also presenting a bundle that must not be accepted
  task automatic flushTo(input string tag, input logic [HIST-1:0] ghr);
    @(negedge i_clk);
    i_flush = 1'b1; i_flushGhr = ghr;
    i_valid = 1'b1; i_bNum_4 = 4'd1; i_weightsAddr_32 = 32'h0000_0005;
    #1;
    checkOutput({tag, "_readyInFlush"}, 32'(o_ready), 32'd0);
    @(negedge i_clk);
    i_flush = 1'b0; i_valid = 1'b0;
    checkOutput({tag, "_ghr"}, 32'(o_ghr), 32'(ghr));
    checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
    checkOutput({tag, "_predNum"}, 32'(o_predNum_3), 32'd0);
    checkOutput({tag, "_predTaken"}, 32'(o_predTaken_4), 32'd0);
    repeat (3) @(negedge i_clk);
    checkOutput({tag, "_notAccepted"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    nAsserts = 0; nFails = 0;
    i_rstn = 1'b0; i_valid = 1'b0; i_bNum_4 = '0; i_weightsAddr_32 = '0;
    i_ready = 1'b0; i_flush = 1'b0; i_flushGhr = '0;
    i_wEn = 1'b0; i_wAddr_8 = '0; i_wData = '0;
    repeat (3) @(negedge i_clk);
    checkOutput("rst_ready", 32'(o_ready), 32'd1);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_ghr", 32'(o_ghr), 32'd0);
    checkOutput("rst_predNum", 32'(o_predNum_3), 32'd0);
    checkOutput("rst_predTaken", 32'(o_predTaken_4), 32'd0);
    i_rstn = 1'b1;

    // Empty bundle: result one edge after acceptance, GHR untouched
    applyStimulus(4'd0, 32'h0, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("t1_cycles", 32'(cycles), 32'd1);
    checkOutput("t1_predNum", 32'(o_predNum_3), 32'd0);
    checkOutput("t1_predTaken", 32'(o_predTaken_4), 32'd0);
    checkOutput("t1_ghr", 32'(o_ghr), 32'h00);
    consume("t1");

    // Zero weights: sum 0 counts as taken, so only branch 0 is evaluated
    applyStimulus(4'd3, 32'h0007_0605, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("t2_cycles", 32'(cycles), 32'd3);
    checkOutput("t2_predNum", 32'(o_predNum_3), 32'd1);
    checkOutput("t2_predTaken", 32'(o_predTaken_4), 32'h1);
    checkOutput("t2_ghr", 32'(o_ghr), 32'h01);
    consume("t2");
    flushTo("f1", 8'h00);

    // Bias -1 everywhere: four not-taken branches, result on cycle 9
    for (int r = 10; r <= 13; r++) writeRow(8'(r), ROW_BIASM1);
    applyStimulus(4'd4, 32'h0D0C_0B0A, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("t3_cycles", 32'(cycles), 32'd9);
    checkOutput("t3_predNum", 32'(o_predNum_3), 32'd4);
    checkOutput("t3_predTaken", 32'(o_predTaken_4), 32'h0);
    checkOutput("t3_ghr", 32'(o_ghr), 32'h00);
    consume("t3");

    // Branch count above 4 behaves as 4
    applyStimulus(4'd9, 32'h0D0C_0B0A, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("clamp_predNum", 32'(o_predNum_3), 32'd4);
    checkOutput("clamp_cycles", 32'(cycles), 32'd9);
    consume("clamp");

    // Row 20: bias -5, w1 +10 on ghr[0]; GHR=0 gives -15, GHR=1 gives +5
    writeRow(8'd20, ROW_20);
    applyStimulus(4'd1, 32'h0000_0014, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("t4a_predTaken", 32'(o_predTaken_4), 32'h0);
    checkOutput("t4a_predNum", 32'(o_predNum_3), 32'd1);
    checkOutput("t4a_ghr", 32'(o_ghr), 32'h00);
    consume("t4a");
    flushTo("f2", 8'h01);
    applyStimulus(4'd1, 32'h0000_0014, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("t4b_predTaken", 32'(o_predTaken_4), 32'h1);
    checkOutput("t4b_ghr", 32'(o_ghr), 32'h03);
    consume("t4b");

    // Address 228 is out of range: write ignored, read as zero -> taken
    writeRow(8'd228, ROW_BIASM1);
    applyStimulus(4'd2, 32'h0000_0AE4, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("oor_predNum", 32'(o_predNum_3), 32'd1);
    checkOutput("oor_predTaken", 32'(o_predTaken_4), 32'h1);
    checkOutput("oor_ghr", 32'(o_ghr), 32'h07);
    consume("oor");

    // Address 227 is the last real row
    writeRow(8'd227, ROW_BIASM1);
    applyStimulus(4'd1, 32'h0000_00E3, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("last_predTaken", 32'(o_predTaken_4), 32'h0);
    checkOutput("last_ghr", 32'(o_ghr), 32'h0E);
    consume("last");

    // Result held while the consumer stalls (GHR 0x0E, ghr[0]=0 -> -15)
    applyStimulus(4'd1, 32'h0000_0014, 1'b0, 8'd0, ROW_ZERO, cycles);
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      checkOutput("hold_valid", 32'(o_valid), 32'd1);
      checkOutput("hold_ready", 32'(o_ready), 32'd0);
      checkOutput("hold_predNum", 32'(o_predNum_3), 32'd1);
      checkOutput("hold_predTaken", 32'(o_predTaken_4), 32'h0);
      checkOutput("hold_ghr", 32'(o_ghr), 32'h1C);
    end
    consume("hold");

    // Flush arriving while the first branch is in SUM
    @(negedge i_clk);
    i_valid = 1'b1; i_bNum_4 = 4'd4; i_weightsAddr_32 = 32'h0D0C_0B0A;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    flushTo("fsum", 8'hA5);
    sawValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      sawValid = sawValid | o_valid;
    end
    checkOutput("fsum_noValid", 32'(sawValid), 32'd0);
    checkOutput("fsum_ghrKept", 32'(o_ghr), 32'hA5);

    // Write to row 30 lands on the same edge as its RD: old (zero) row used
    applyStimulus(4'd1, 32'h0000_001E, 1'b1, 8'd30, ROW_BIASM1, cycles);
    checkOutput("t6a_predTaken", 32'(o_predTaken_4), 32'h1);
    checkOutput("t6a_ghr", 32'(o_ghr), 32'h4B);
    consume("t6a");
    applyStimulus(4'd1, 32'h0000_001E, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("t6b_predTaken", 32'(o_predTaken_4), 32'h0);
    checkOutput("t6b_ghr", 32'(o_ghr), 32'h96);
    consume("t6b");

    // Not-taken then taken: stops after branch 1
    applyStimulus(4'd3, 32'h0706_050A, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("mix_cycles", 32'(cycles), 32'd5);
    checkOutput("mix_predNum", 32'(o_predNum_3), 32'd2);
    checkOutput("mix_predTaken", 32'(o_predTaken_4), 32'h2);
    checkOutput("mix_ghr", 32'(o_ghr), 32'h59);
    consume("mix");

    // Reset in the middle of a bundle clears state and weights
    @(negedge i_clk);
    i_valid = 1'b1; i_bNum_4 = 4'd4; i_weightsAddr_32 = 32'h0D0C_0B0A;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    checkOutput("mrst_valid", 32'(o_valid), 32'd0);
    checkOutput("mrst_ready", 32'(o_ready), 32'd1);
    checkOutput("mrst_ghr", 32'(o_ghr), 32'h00);
    @(negedge i_clk);
    i_rstn = 1'b1;
    applyStimulus(4'd1, 32'h0000_000A, 1'b0, 8'd0, ROW_ZERO, cycles);
    checkOutput("mrst_rowCleared", 32'(o_predTaken_4), 32'h1);
    checkOutput("mrst_ghrAfter", 32'(o_ghr), 32'h01);
    consume("mrst");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
